// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Tracks control information for the ID/EX, EX/MEM and MEM/WB pipeline
//   registers of a 5-stage in-order pipeline. It selects the forwarding
//   source for the two EX-stage operand muxes and detects load-use hazards.
//   On a load-use hazard it stalls for one cycle and injects a bubble.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   id_valid       ID stage holds a real instruction
//   id_rs1/id_rs2  ID source register numbers
//   id_use_rs1/2   ID instruction actually reads rs1 / rs2
//   id_rd          ID destination register
//   id_reg_write   ID instruction writes rd
//   id_mem_read    ID instruction is a load
//   flush          branch taken in EX; squash the instruction entering EX
//   fwd_a_sel      operand A source: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   fwd_b_sel      operand B source, same encoding as fwd_a_sel
//   stall          hold PC and IF/ID this cycle
//   ex_valid       EX stage holds a real instruction
//   stall_count    saturating count of stall cycles
module hazard_forward_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic        ex_valid,
  output logic [15:0] stall_count
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  logic        idex_valid;
  logic [4:0]  idex_rs1;
  logic [4:0]  idex_rs2;
  logic [4:0]  idex_rd;
  logic        idex_reg_write;
  logic        idex_mem_read;

  logic        exmem_valid;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;

  logic        memwb_valid;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;

  logic [15:0] stall_cnt_q;

  logic        exmem_fwd_ok;
  logic        memwb_fwd_ok;
  logic        load_use;
  logic        accept_id;

  // A stage can only be a forwarding source if it actually writes a
  // non-zero register; bubbles have valid=0 and reg_write=0.
  assign exmem_fwd_ok = exmem_valid & exmem_reg_write & (exmem_rd != 5'd0);
  assign memwb_fwd_ok = memwb_valid & memwb_reg_write & (memwb_rd != 5'd0);

  // EX/MEM is checked first so the youngest producer wins.
  always_comb begin
    fwd_a_sel = SEL_RF;
    if (exmem_fwd_ok && (exmem_rd == idex_rs1))
      fwd_a_sel = SEL_EXMEM;
    else if (memwb_fwd_ok && (memwb_rd == idex_rs1))
      fwd_a_sel = SEL_MEMWB;
  end

  always_comb begin
    fwd_b_sel = SEL_RF;
    if (exmem_fwd_ok && (exmem_rd == idex_rs2))
      fwd_b_sel = SEL_EXMEM;
    else if (memwb_fwd_ok && (memwb_rd == idex_rs2))
      fwd_b_sel = SEL_MEMWB;
  end

  // Load data is not available until MEM, so a consumer right behind a
  // load waits one cycle; a taken branch squashes it instead.
  assign load_use = id_valid & idex_mem_read & (idex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == idex_rd)) |
                     (id_use_rs2 & (id_rs2 == idex_rd)));
  assign stall     = load_use & ~flush;
  assign accept_id = ~stall & ~flush;

  assign ex_valid    = idex_valid;
  assign stall_count = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid      <= 1'b0;
      idex_rs1        <= 5'd0;
      idex_rs2        <= 5'd0;
      idex_rd         <= 5'd0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      exmem_valid     <= 1'b0;
      exmem_rd        <= 5'd0;
      exmem_reg_write <= 1'b0;
      memwb_valid     <= 1'b0;
      memwb_rd        <= 5'd0;
      memwb_reg_write <= 1'b0;
      stall_cnt_q     <= 16'd0;
    end else begin
      exmem_valid     <= idex_valid;
      exmem_rd        <= idex_rd;
      exmem_reg_write <= idex_reg_write;
      memwb_valid     <= exmem_valid;
      memwb_rd        <= exmem_rd;
      memwb_reg_write <= exmem_reg_write;

      if (accept_id) begin
        idex_valid     <= id_valid;
        idex_rs1       <= id_rs1;
        idex_rs2       <= id_rs2;
        idex_rd        <= id_rd;
        idex_reg_write <= id_reg_write;
        idex_mem_read  <= id_mem_read;
      end else begin
        idex_valid     <= 1'b0;
        idex_rs1       <= 5'd0;
        idex_rs2       <= 5'd0;
        idex_rd        <= 5'd0;
        idex_reg_write <= 1'b0;
        idex_mem_read  <= 1'b0;
      end

      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_reg_write, id_mem_read;
  logic        flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, ex_valid;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  hazard_forward_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es, ex;
    logic [15:0] ec;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic fl,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic es, input logic ex, input logic [15:0] ec);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.mr = mr; r.fl = fl;
    r.ea = ea; r.eb = eb; r.es = es; r.ex = ex; r.ec = ec;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                         input logic es, input logic ex, input logic [15:0] ec);
    chk({tag, " fwd_a"}, {14'd0, fwd_a_sel}, {14'd0, ea});
    chk({tag, " fwd_b"}, {14'd0, fwd_b_sel}, {14'd0, eb});
    chk({tag, " stall"}, {15'd0, stall}, {15'd0, es});
    chk({tag, " ex_valid"}, {15'd0, ex_valid}, {15'd0, ex});
    chk({tag, " stall_count"}, stall_count, ec);
  endtask

  initial begin
    // ALU forwarding at distance 1 and 2
    tbl[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0,  0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 3, 4, 1, 1, 5, 1, 0, 0,  2, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[4]  = mk(1, 1, 5, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    // two producers of x5: youngest wins
    tbl[6]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 1, 1, 5, 1, 0, 0,  0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 1, 0);
    // x0 destination and non-writing producer never forward
    tbl[10] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[11] = mk(1, 3, 2, 1, 1, 3, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[12] = mk(1, 0, 3, 1, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    // load-use: lw x8 ; add x9,x8,x8 (held one cycle)
    tbl[14] = mk(1, 1, 0, 1, 0, 8, 1, 1, 0,  0, 0, 0, 0, 0);
    tbl[15] = mk(1, 8, 8, 1, 1, 9, 1, 0, 0,  0, 0, 1, 1, 0);
    tbl[16] = mk(1, 8, 8, 1, 1, 9, 1, 0, 0,  0, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    // flush with pending load-use
    tbl[19] = mk(1, 2, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(1, 12, 0, 1, 1, 13, 1, 0, 1, 0, 0, 0, 1, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    // reset with live inputs that would otherwise load a load into ID/EX
    rst_n = 1'b0;
    drive(1, 8, 8, 1, 1, 8, 1, 1, 0);
    #1;
    chk_all("reset_t0", 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset_held", 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ex, tbl[i].ec);
      @(posedge clk); #1;
    end

    // reset asserted in the middle of a stall
    drive(1, 1, 0, 1, 0, 8, 1, 1, 0);
    @(posedge clk); #1;
    drive(1, 8, 8, 1, 1, 9, 1, 0, 0);
    @(negedge clk);
    chk("midrst pre stall", {15'd0, stall}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk_all("midrst now", 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all("midrst held", 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("postrst stall", {15'd0, stall}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all("postrst load", 2'b00, 2'b00, 1'b0, 1'b1, 16'd0);

    // self-dependent load: stalls every other cycle
    @(posedge clk); #1;
    drive(1, 8, 0, 1, 0, 8, 1, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("cnt%0d stall", k), {15'd0, stall}, 16'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("cnt%0d count", k), stall_count, 16'(k));
      chk($sformatf("cnt%0d bubble", k), {15'd0, ex_valid}, 16'd0);
    end

    // jump the counter close to its ceiling, then keep stalling
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d stall", k), {15'd0, stall}, 16'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d count", k), stall_count, (k >= 2) ? 16'hFFFF : 16'hFFFE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
